// File: rtl/sysbus_pkg.sv
// System-bus command/space encodings and the line-reader FSM state type.
// Shared by the line reader, its interface and the bench.
package sysbus_pkg;

    localparam logic [2:0] SYSBUS_READ   = 3'b001;
    localparam logic [2:0] SYSBUS_WRITE  = 3'b010;
    localparam logic [1:0] SYSBUS_MEMORY = 2'b01;
    localparam logic [1:0] SYSBUS_MMIO   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    // Port-id width; a single requester still gets a 1-bit id.
    function automatic int port_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_line_reader_if.sv
// Requester and system-bus signals of the line reader; master is the reader,
// slave is the requesters plus bus fabric.
interface bus_line_reader_if
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8,
    parameter int N_PORTS        = 2
) ();
    localparam int LINE_BITS = BUS_DATA_WIDTH * LINE_BEATS;
    localparam int PORT_W    = port_width(N_PORTS);

    logic [N_PORTS-1:0]       req_valid;
    logic [N_PORTS*64-1:0]    req_addr;
    logic [N_PORTS-1:0]       req_ready;
    logic                     resp_valid;
    logic [PORT_W-1:0]        resp_port;
    logic [LINE_BITS-1:0]     resp_data;
    logic                     bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0] bus_reqtag;
    logic                     bus_reqack;
    logic                     bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0] bus_resptag;
    logic                     bus_respack;

    modport master (
        input  req_valid, req_addr, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output req_ready, resp_valid, resp_port, resp_data,
               bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    modport slave (
        output req_valid, req_addr, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  req_ready, resp_valid, resp_port, resp_data,
               bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Purely combinational; ptr must be below N.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [N-1:0] rot;
    logic [N-1:0] first;
    logic [N-1:0] rot_unused;
    logic [N-1:0] gnt_unused;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        {rot_unused, rot} = {req, req} >> ptr;
        first             = rot & (~rot + N'(1));
        {grant, gnt_unused} = {first, first} << ptr;
    end

endmodule

// File: rtl/bus_line_reader.sv
// Fetches one cache line per granted requester over the system bus, beat by beat.
// resp_valid one cycle after the last beat; one request outstanding, bus stalls tolerated.
module bus_line_reader
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8,
    parameter int N_PORTS        = 2
) (
    input  logic              clk,
    input  logic              reset,
    bus_line_reader_if.master io
);

    localparam int LINE_BITS = BUS_DATA_WIDTH * LINE_BEATS;
    localparam int OFS_W     = $clog2(LINE_BITS / 8);
    localparam int PORT_W    = port_width(N_PORTS);
    localparam int CNT_W     = $clog2(LINE_BEATS);
    localparam logic [63:0]      LINE_MASK = ~((64'd1 << OFS_W) - 64'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    state_t                    state;
    logic [PORT_W-1:0]         rr_ptr;
    logic [PORT_W-1:0]         port_id;
    logic [PORT_W-1:0]         sel_id;
    logic [CNT_W-1:0]          beat_cnt;
    logic [BUS_DATA_WIDTH-1:0] bus_req_q;
    logic                      bus_reqcyc_q;
    logic                      resp_valid_q;
    logic [LINE_BITS-1:0]      line_buf;
    logic [LINE_BITS-1:0]      line_next;
    logic [LINE_BITS-1:0]      resp_data_q;
    logic [N_PORTS-1:0]        grant;
    logic [63:0]               sel_addr;
    logic                      resptag_unused;

    rr_arbiter #(.N(N_PORTS)) u_arb (
        .req   (io.req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        sel_id = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) sel_id = PORT_W'(i);
        end
    end

    assign sel_addr = io.req_addr[{sel_id, 6'b0} +: 64];

    // Assembly buffer with the current beat merged in; also the final line image.
    for (genvar b = 0; b < LINE_BEATS; b++) begin : g_beat
        assign line_next[b*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] =
            (beat_cnt == CNT_W'(b)) ? io.bus_resp : line_buf[b*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            port_id      <= '0;
            beat_cnt     <= '0;
            bus_req_q    <= '0;
            bus_reqcyc_q <= 1'b0;
            resp_valid_q <= 1'b0;
            line_buf     <= '0;
            resp_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        bus_req_q    <= BUS_DATA_WIDTH'(sel_addr & LINE_MASK);
                        port_id      <= sel_id;
                        bus_reqcyc_q <= 1'b1;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (io.bus_reqack) begin
                        bus_reqcyc_q <= 1'b0;
                        beat_cnt     <= '0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (io.bus_respcyc) begin
                        line_buf <= line_next;
                        if (beat_cnt == LAST_BEAT) begin
                            resp_data_q  <= line_next;
                            resp_valid_q <= 1'b1;
                            state        <= DONE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    resp_valid_q <= 1'b0;
                    rr_ptr       <= (port_id == PORT_W'(N_PORTS - 1)) ? '0 : port_id + PORT_W'(1);
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.req_ready   = (state == IDLE && !reset) ? grant : '0;
    assign io.bus_respack = (state == RESP) && io.bus_respcyc;
    assign io.bus_reqcyc  = bus_reqcyc_q;
    assign io.bus_req     = bus_req_q;
    assign io.bus_reqtag  = BUS_TAG_WIDTH'({SYSBUS_READ, SYSBUS_MEMORY, 8'(port_id)});
    assign io.resp_valid  = resp_valid_q;
    assign io.resp_port   = port_id;
    assign io.resp_data   = resp_data_q;

    // Response tags are not checked; only one request is ever in flight.
    assign resptag_unused = ^io.bus_resptag;

endmodule

// File: tb/tb_bus_line_reader.sv
// Randomized scoreboard bench for bus_line_reader: default 2-port/8-beat instance
// plus a 4-port/4-beat instance for grant rotation.
module tb_bus_line_reader;
    import sysbus_pkg::*;

    localparam int DW     = 64;
    localparam int TW     = 13;
    localparam int LB     = 8;
    localparam int NP     = 2;
    localparam int LBITS  = DW * LB;
    localparam int LB2    = 4;
    localparam int NP2    = 4;
    localparam int LBITS2 = DW * LB2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    bus_line_reader_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .LINE_BEATS(LB), .N_PORTS(NP)) ifa ();
    bus_line_reader_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .LINE_BEATS(LB2), .N_PORTS(NP2)) ifb ();

    bus_line_reader #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .LINE_BEATS(LB), .N_PORTS(NP)) u_a (
        .clk(clk), .reset(reset), .io(ifa));
    bus_line_reader #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .LINE_BEATS(LB2), .N_PORTS(NP2)) u_b (
        .clk(clk), .reset(reset), .io(ifb));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: pending requests, rotation pointer, last completed line.
    typedef struct {
        int               port;
        logic [LBITS-1:0] data;
    } exp_t;
    exp_t             sb[$];
    exp_t             mon_e;
    logic [NP-1:0]    pend;
    logic [63:0]      addr[NP];
    int               rr_ptr = 0;
    logic [LBITS-1:0] last_line = '0;
    int               last_beat_cyc = 0;
    bit               prev_rv = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_rv = 1'b0;
        end else begin
            if (prev_rv) chk("resp_valid_one_cycle", ifa.resp_valid, 0);
            if (ifa.resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp_valid", ifa.resp_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_port", ifa.resp_port, mon_e.port);
                    chk("resp_data", ifa.resp_data, mon_e.data);
                    chk("resp_latency", cyc, last_beat_cyc);
                    last_line = mon_e.data;
                end
            end
            prev_rv = ifa.resp_valid;
        end
    end

    task automatic drive_reqs();
        for (int p = 0; p < NP; p++) begin
            ifa.req_valid[p]          = pend[p];
            ifa.req_addr[p*64 +: 64]  = addr[p];
        end
    endtask

    // One line fetch on instance A. gap<0 means random gaps; abort_after>=0 resets after that beat.
    task automatic do_txn(input int ack_dly, input int gap, input bit seq_beats,
                          input int abort_after, input bit fill_all);
        int               exp_port;
        int               c;
        int               g;
        logic [63:0]      exp_addr;
        logic [LBITS-1:0] line;
        for (int p = 0; p < NP; p++) begin
            if (!pend[p] && (fill_all || $urandom_range(0, 1) == 1)) begin
                pend[p] = 1'b1;
                addr[p] = {$urandom, $urandom};
            end
        end
        if (pend == '0) begin
            c = $urandom_range(0, NP - 1);
            pend[c] = 1'b1;
            addr[c] = {$urandom, $urandom};
        end
        drive_reqs();
        exp_port = 0;
        for (int k = NP - 1; k >= 0; k--) begin
            c = (rr_ptr + k) % NP;
            if (pend[c]) exp_port = c;
        end
        @(negedge clk);
        chk("req_ready_grant", ifa.req_ready, 1 << exp_port);
        exp_addr = addr[exp_port] & ~64'h3f;
        for (int k = 0; k < LB; k++)
            line[k*DW +: DW] = seq_beats ? 64'(k) : {$urandom, $urandom};
        if (abort_after < 0) sb.push_back('{exp_port, line});
        @(posedge clk); #1;
        pend[exp_port] = 1'b0;
        drive_reqs();
        for (int i = 0; i <= ack_dly; i++) begin
            ifa.bus_reqack  = (i == ack_dly);
            ifa.bus_respcyc = 1'($urandom_range(0, 1));
            ifa.bus_resp    = {$urandom, $urandom};
            @(negedge clk);
            chk("bus_reqcyc_held", ifa.bus_reqcyc, 1);
            chk("bus_req_addr", ifa.bus_req, exp_addr);
            chk("bus_reqtag", ifa.bus_reqtag, {SYSBUS_READ, SYSBUS_MEMORY, 8'(exp_port)});
            chk("req_ready_busy", ifa.req_ready, 0);
            chk("respack_in_req", ifa.bus_respack, 0);
            @(posedge clk); #1;
        end
        ifa.bus_reqack  = 1'b0;
        ifa.bus_respcyc = 1'b0;
        for (int k = 0; k < LB; k++) begin
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            repeat (g) begin
                ifa.bus_respcyc = 1'b0;
                ifa.bus_resp    = {$urandom, $urandom};
                @(negedge clk);
                chk("respack_gap", ifa.bus_respack, 0);
                chk("bus_reqcyc_dropped", ifa.bus_reqcyc, 0);
                @(posedge clk); #1;
            end
            ifa.bus_respcyc = 1'b1;
            ifa.bus_resp    = line[k*DW +: DW];
            @(negedge clk);
            chk("respack_beat", ifa.bus_respack, 1);
            if (k == LB / 2) chk("resp_data_held", ifa.resp_data, last_line);
            @(posedge clk); #1;
            last_beat_cyc = cyc;
            if (k == abort_after) begin
                ifa.bus_respcyc = 1'b0;
                ifa.req_valid   = '0;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                chk("abort_resp_valid", ifa.resp_valid, 0);
                chk("abort_resp_data", ifa.resp_data, 0);
                chk("abort_reqcyc", ifa.bus_reqcyc, 0);
                chk("abort_resp_port", ifa.resp_port, 0);
                rr_ptr    = 0;
                last_line = '0;
                @(posedge clk); #1;
                return;
            end
        end
        // A stray beat while DONE must not be acked.
        ifa.bus_respcyc = 1'b1;
        ifa.bus_resp    = {$urandom, $urandom};
        @(negedge clk);
        chk("respack_done", ifa.bus_respack, 0);
        chk("req_ready_done", ifa.req_ready, 0);
        @(posedge clk); #1;
        ifa.bus_respcyc = 1'b0;
        rr_ptr = (exp_port + 1) % NP;
    endtask

    initial begin
        int               w;
        logic [LBITS2-1:0] line2;
        reset = 1'b1;
        pend  = '1;
        addr[0] = {$urandom, $urandom};
        addr[1] = 64'h1234_5678;
        drive_reqs();
        ifa.bus_reqack = 1'b0; ifa.bus_respcyc = 1'b1; ifa.bus_resp = '0; ifa.bus_resptag = '0;
        ifb.req_valid = '0; ifb.req_addr = '0;
        ifb.bus_reqack = 1'b0; ifb.bus_respcyc = 1'b0; ifb.bus_resp = '0; ifb.bus_resptag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", ifa.req_ready, 0);
        chk("rst_bus_reqcyc", ifa.bus_reqcyc, 0);
        chk("rst_bus_respack", ifa.bus_respack, 0);
        chk("rst_resp_valid", ifa.resp_valid, 0);
        chk("rst_resp_data", ifa.resp_data, 0);
        chk("rst_resp_port", ifa.resp_port, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        ifa.bus_respcyc = 1'b0;

        do_txn(1, 0, 1'b0, -1, 1'b1);          // both pending: port 0 first
        do_txn(3, 0, 1'b1, -1, 1'b1);          // port 1, 0x12345678, beats 0..7
        do_txn(0, 2, 1'b0, -1, 1'b1);          // port 0 again, 2-cycle gaps
        repeat (20) do_txn($urandom_range(0, 3), -1, 1'b0, -1, 1'b0);
        do_txn(1, 0, 1'b0, 3, 1'b0);           // reset after beat 3
        repeat (5) do_txn($urandom_range(0, 3), -1, 1'b0, -1, 1'b0);
        chk("scoreboard_drained", sb.size(), 0);

        // Wide instance: constant requests on all four ports.
        ifa.req_valid = '0;
        reset = 1'b1;
        ifb.req_valid = '1;
        for (int p = 0; p < NP2; p++) ifb.req_addr[p*64 +: 64] = {$urandom, $urandom};
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int t = 0; t < 5; t++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (ifb.req_ready == '0 && w < 10);
            chk("b_grant_order", ifb.req_ready, 1 << (t % NP2));
            @(posedge clk); #1;
            ifb.bus_reqack = 1'b1;
            @(posedge clk); #1;
            ifb.bus_reqack = 1'b0;
            for (int k = 0; k < LB2; k++) begin
                line2[k*DW +: DW] = {32'(t), $urandom};
                ifb.bus_respcyc   = 1'b1;
                ifb.bus_resp      = line2[k*DW +: DW];
                @(posedge clk); #1;
            end
            ifb.bus_respcyc = 1'b0;
            @(negedge clk);
            chk("b_resp_valid", ifb.resp_valid, 1);
            chk("b_resp_port", ifb.resp_port, t % NP2);
            chk("b_resp_data", ifb.resp_data, line2);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
